// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector: per-channel synchroniser, glitch filter,
// registered level with rising/falling pulses, mode-qualified event,
// sticky flag and saturating event counter.
module multi_edge_detector #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           sig_in,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clr,
  output logic [CHANNELS-1:0]           level_out,
  output logic [CHANNELS-1:0]           posedge_out,
  output logic [CHANNELS-1:0]           negedge_out,
  output logic [CHANNELS-1:0]           event_out,
  output logic [CHANNELS-1:0]           sticky_out,
  output logic [CHANNELS*CNT_WIDTH-1:0] event_count
);

  localparam int FW = $clog2(FILTER_CYCLES) + 1;
  localparam logic [FW-1:0]        FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_i;
    logic [FW-1:0]          filt_cnt;
    logic                   level_q;
    logic                   level_d;
    logic                   rise;
    logic                   fall;
    logic                   evt;
    logic                   sticky_q;
    logic [CNT_WIDTH-1:0]   cnt_q;

    assign sync_i = sync_q[SYNC_STAGES-1];

    // Shift the raw input through the synchroniser chain
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in[i]};
    end

    // Toggle the filtered level after FILTER_CYCLES consecutive mismatches
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        filt_cnt <= '0;
        level_q  <= 1'b0;
      end else if (sync_i != level_q) begin
        if (filt_cnt == FILT_LAST) begin
          filt_cnt <= '0;
          level_q  <= ~level_q;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end

    // Delayed copy of the filtered level for edge extraction
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) level_d <= 1'b0;
      else        level_d <= level_q;
    end

    assign rise = level_q & ~level_d;
    assign fall = ~level_q & level_d;
    assign evt  = (rise & mode[2*i]) | (fall & mode[2*i+1]);

    // Sticky flag: an event in the same cycle as clr keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)      sticky_q <= 1'b0;
      else if (evt)    sticky_q <= 1'b1;
      else if (clr[i]) sticky_q <= 1'b0;
    end

    // Saturating event counter; clr with a coincident event restarts at 1
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    cnt_q <= '0;
      else if (clr[i])               cnt_q <= evt ? CNT_WIDTH'(1) : '0;
      else if (evt && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end

    assign level_out[i]                        = level_q;
    assign posedge_out[i]                      = rise;
    assign negedge_out[i]                      = fall;
    assign event_out[i]                        = evt;
    assign sticky_out[i]                       = sticky_q;
    assign event_count[CNT_WIDTH*i +: CNT_WIDTH] = cnt_q;
  end

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (4 channels, S=2, F=3, 2-bit counters).
module tb_multi_edge_detector;

  localparam int CH = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] sig_in;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] clr;
  logic [CH-1:0] level_out, posedge_out, negedge_out, event_out, sticky_out;
  logic [CH*CW-1:0] event_count;

  int checks   = 0;
  int failures = 0;

  multi_edge_detector #(
    .CHANNELS(CH), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .sig_in(sig_in), .mode(mode), .clr(clr),
    .level_out(level_out), .posedge_out(posedge_out), .negedge_out(negedge_out),
    .event_out(event_out), .sticky_out(sticky_out), .event_count(event_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sig;
    logic [7:0] md;
    logic [3:0] cl;
    logic [3:0] lvl;
    logic [3:0] pos;
    logic [3:0] neg;
    logic [3:0] evt;
  } vec_t;

  vec_t vec [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_level"},  32'(level_out),   0);
    check({name, "_pos"},    32'(posedge_out), 0);
    check({name, "_neg"},    32'(negedge_out), 0);
    check({name, "_event"},  32'(event_out),   0);
    check({name, "_sticky"}, 32'(sticky_out),  0);
    check({name, "_count"},  32'(event_count), 0);
  endtask

  initial begin
    bit found;

    // ch0: 2-cycle glitch at steps 0-1, then every channel gets a 3-cycle pulse
    // at steps 6-8. Rise visible at step 10, fall at step 13.
    // mode: ch0=00, ch1=11, ch2=01, ch3=10.
    for (int i = 0; i < 15; i++) begin
      vec[i].sig = 4'h0; vec[i].md = 8'h9C; vec[i].cl = 4'h0;
      vec[i].lvl = (i >= 10 && i <= 12) ? 4'hF : 4'h0;
      vec[i].pos = (i == 10) ? 4'hF : 4'h0;
      vec[i].neg = (i == 13) ? 4'hF : 4'h0;
      vec[i].evt = (i == 10) ? 4'b0110 : (i == 13) ? 4'b1010 : 4'h0;
    end
    vec[0].sig = 4'b0001;
    vec[1].sig = 4'b0001;
    for (int i = 6; i <= 8; i++) vec[i].sig = 4'hF;

    // Reset held with inputs high
    reset = 1'b0; sig_in = 4'hF; mode = 8'h00; clr = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    reset = 1'b1;
    for (int n = 1; n <= 4; n++) step();
    check("rst_rel_lvl_e4", 32'(level_out), 32'h0);
    step();
    check("rst_rel_lvl_e5", 32'(level_out),   32'hF);
    check("rst_rel_pos_e5", 32'(posedge_out), 32'hF);
    check("rst_rel_evt_e5", 32'(event_out),   32'h0);
    step();
    check("rst_rel_pos_e6", 32'(posedge_out), 32'h0);
    check("rst_rel_lvl_e6", 32'(level_out),   32'hF);
    sig_in = 4'h0;
    repeat (8) step();
    check("rst_rel_fallen", 32'(level_out),   32'h0);
    check("rst_rel_count",  32'(event_count), 32'h0);
    check("rst_rel_sticky", 32'(sticky_out),  32'h0);

    // Table: glitch rejection and mode-qualified events
    for (int i = 0; i < 15; i++) begin
      sig_in = vec[i].sig; mode = vec[i].md; clr = vec[i].cl;
      step();
      check($sformatf("vec%0d_level", i), 32'(level_out),   32'(vec[i].lvl));
      check($sformatf("vec%0d_pos", i),   32'(posedge_out), 32'(vec[i].pos));
      check($sformatf("vec%0d_neg", i),   32'(negedge_out), 32'(vec[i].neg));
      check($sformatf("vec%0d_event", i), 32'(event_out),   32'(vec[i].evt));
    end
    check("tbl_count",  32'(event_count), 32'h58);
    check("tbl_sticky", 32'(sticky_out),  32'hE);

    // Mode change alone must not create events
    mode = 8'hFF;
    for (int n = 0; n < 3; n++) begin
      #1;
      check($sformatf("mode_only_evt%0d", n), 32'(event_out), 32'h0);
      step();
    end
    check("mode_only_count", 32'(event_count), 32'h58);

    // Saturation and clear on ch2
    mode = 8'h10;
    clr = 4'b0100; step(); clr = 4'h0;
    check("ch2_clr0_count", 32'(event_count[4 +: 2]), 32'd0);
    check("ch2_clr0_sticky", 32'(sticky_out), 32'hA);
    for (int p = 0; p < 5; p++) begin
      sig_in = 4'b0100; repeat (4) step();
      sig_in = 4'b0000; repeat (5) step();
    end
    check("ch2_sat_count",  32'(event_count[4 +: 2]), 32'd3);
    check("ch2_sat_sticky", 32'(sticky_out[2]), 32'd1);
    check("ch1_indep_count", 32'(event_count[2 +: 2]), 32'd2);
    clr = 4'b0100; step(); clr = 4'h0;
    check("ch2_clr_count",  32'(event_count[4 +: 2]), 32'd0);
    check("ch2_clr_sticky", 32'(sticky_out[2]), 32'd0);

    // Event and clr in the same cycle on ch3
    mode = 8'h40; sig_in = 4'b1000;
    found = 1'b0;
    for (int n = 0; n < 12 && !found; n++) begin
      step();
      if (event_out[3]) found = 1'b1;
    end
    check("ch3_event_seen", 32'(found), 32'd1);
    clr = 4'b1000; step(); clr = 4'h0;
    check("ch3_simul_sticky", 32'(sticky_out[3]), 32'd1);
    check("ch3_simul_count",  32'(event_count[6 +: 2]), 32'd1);
    sig_in = 4'h0; repeat (8) step();

    // Reset asserted while ch0's filter counter holds 2
    mode = 8'hFF; sig_in = 4'b0001;
    repeat (4) step();
    check("midflt_lvl_before", 32'(level_out), 32'h0);
    sig_in = 4'h0; reset = 1'b0;
    #1;
    check_all_zero("midflt_reset");
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step();
      check($sformatf("midflt_rel_pos%0d", n), 32'(posedge_out | level_out), 32'h0);
    end
    check("midflt_rel_count", 32'(event_count), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
Parametrised multi-channel edge detector for the SPI block and other asynchronous control inputs (SCK, CS_n, external strobes). For each channel it synchronises the input, rejects glitches, and produces a filtered level plus single-cycle rising and falling pulses. Each channel also has a mode-qualified event pulse, a sticky flag and a saturating event counter. A host or controller FSM can poll or clear these per channel.

Parameters:
CHANNELS, 4, number of independent input channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILTER_CYCLES, 3, consecutive mismatching cycles required before the filtered level changes (>=1; 1 = no filtering)
CNT_WIDTH, 8, width of each per-channel event counter

Ports:
clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
sig_in  input  CHANNELS  raw asynchronous inputs
mode  input  2*CHANNELS  per-channel event select; bits [2i+1:2i]: 00 none, 01 rising, 10 falling, 11 both
clr  input  CHANNELS  per-channel synchronous clear of sticky flag and counter
level_out  output  CHANNELS  filtered, synchronised level
posedge_out  output  CHANNELS  one-cycle pulse on filtered 0->1
negedge_out  output  CHANNELS  one-cycle pulse on filtered 1->0
event_out  output  CHANNELS  mode-qualified edge pulse
sticky_out  output  CHANNELS  latched event flag
event_count  output  CHANNELS*CNT_WIDTH  per-channel saturating event count; channel i at [CNT_WIDTH*i +: CNT_WIDTH]

Behaviour:
- Reset (reset=0, async): all synchroniser flops, filter counters, level_out, level_d, sticky_out and event_count go to 0. posedge_out, negedge_out and event_out are therefore 0.
- Channels are fully independent; no cross-channel interaction.
- Synchroniser: SYNC_STAGES-flop shift chain per channel; sync_i is the last stage.
- Glitch filter, per channel:
  - A counter of width clog2(FILTER_CYCLES)+1 counts consecutive edges with sync_i != level_out[i].
  - The counter resets to 0 on any edge where the two are equal.
  - On the FILTER_CYCLES-th consecutive mismatching edge, level_out toggles and the counter clears.
  - Sync pulses shorter than FILTER_CYCLES cycles never reach level_out.
- Latency: let edge k be the first edge that samples the new sig_in value into stage 1. level_out changes at edge k+SYNC_STAGES+FILTER_CYCLES-1. Example: S=2, F=3 gives edge k+4.
- Edge pulses:
  - level_d is level_out delayed one cycle.
  - posedge_out = level_out & ~level_d; negedge_out = ~level_out & level_d.
  - Each pulse is high exactly one cycle, the first cycle of the new level, and is glitch-free because both terms are registered.
- event_out[i] = (posedge_out[i] & mode[2i]) | (negedge_out[i] & mode[2i+1]).
  - mode is sampled combinationally, so a change takes effect immediately.
  - A mode change alone never creates an event.
- Sticky flag:
  - Set at the edge ending a cycle with event_out=1.
  - Cleared at the edge ending a cycle with clr=1.
  - Simultaneous event and clr: flag ends at 1 (event wins).
- Counter:
  - Increments at the edge ending an event cycle.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - clr sets it to 0; simultaneous clr and event sets it to 1.
- Reset mid-operation: all state returns to 0 immediately. If sig_in is high after reset release, it is treated as a normal 0->1 transition and yields a rising edge with normal latency.
- Both edges inside one filter window: a pulse shorter than FILTER_CYCLES is suppressed entirely, so neither edge is reported.

Test Plan:
- Reset: hold reset=0 with sig_in=4'hF -> all outputs 0. Release reset -> level_out=4'hF after 4 edges; posedge_out=4'hF for 1 cycle; event_count unchanged with mode=0.
- Glitch rejection (S=2, F=3): ch0 sig_in high for 2 cycles -> level_out[0] stays 0, no pulses. High for 3 cycles -> level_out[0]=1 at edge k+4, posedge_out[0] 1 cycle, and 3 cycles later negedge_out[0] 1 cycle.
- Mode select: ch1 mode=01, one full high pulse -> event_out[1] once on the rise, count=1. mode=10 -> once on the fall. mode=11 -> twice, count=2. mode=00 -> none.
- Saturation/clear: CNT_WIDTH=2, 5 events on ch2 -> count=3, sticky=1. clr[2] pulsed alone -> count=0, sticky=0.
- Simultaneous: clr[3] asserted in the same cycle as event_out[3] -> sticky_out[3]=1, count=1.
- Reset mid-filter: assert reset while ch0's filter counter=2 -> all outputs 0 immediately. After release with sig_in low -> no pulse.
